// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and mem_ctl: first-word-fall-through byte buffer
// with sticky overrun/break status and a level-threshold indication.
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_break,
    input  logic                     rd_en,
    input  logic                     clr_flags,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     level_hit,
    output logic                     overrun,
    output logic                     brk
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          brk_q, brk_d;

    logic          do_push, do_pop, ovr_set;

    // Handshake: rx_valid is a one-cycle strobe with no backpressure, so a byte
    // that finds no room is lost and flagged; rd_en pops the head that mem_ctl
    // consumes in the same cycle, and is ignored while empty.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign level_hit = (count_q >= CW'(THRESH));
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign brk       = brk_q;
    assign rd_data   = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = rd_en && !empty;
    assign do_push = rx_valid && !rx_break && (!full || do_pop);
    assign ovr_set = rx_valid && !rx_break && full && !do_pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        brk_d     = brk_q;

        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle set wins.
        if (clr_flags) begin
            overrun_d = 1'b0;
            brk_d     = 1'b0;
        end
        if (ovr_set)  overrun_d = 1'b1;
        if (rx_break) brk_d     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            brk_q     <= brk_d;
        end
    end

    // Storage is deliberately not reset; empty gates its visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8, THRESH=4) with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_break;
    logic       rd_en;
    logic       clr_flags;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       level_hit;
    logic       overrun;
    logic       brk;

    int total;
    int bad;

    uart_rx_fifo #(.DEPTH(8), .THRESH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_break  (rx_break),
        .rd_en     (rd_en),
        .clr_flags (clr_flags),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .level_hit (level_hit),
        .overrun   (overrun),
        .brk       (brk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        rx_break  = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_empty"}, empty, 0);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        tick();
    endtask

    task automatic push_pop(input string tag, input logic [7:0] d, input logic [7:0] exp);
        check(tag, rd_data, exp);
        rx_valid = 1'b1;
        rx_data  = d;
        rd_en    = 1'b1;
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_break  = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            check("rst_empty", empty, 1);
            check("rst_count", count, 0);
            check("rst_full", full, 0);
            check("rst_level", level_hit, 0);
            check("rst_overrun", overrun, 0);
            check("rst_brk", brk, 0);
            tick();
        end

        // Basic ordering
        push(8'h41);
        check("first_rd", rd_data, 8'h41);
        check("first_empty", empty, 0);
        push(8'h42);
        push(8'h43);
        check("abc_count", count, 3);
        pop_check("pop_a", 8'h41);
        pop_check("pop_b", 8'h42);
        pop_check("pop_c", 8'h43);
        check("abc_empty", empty, 1);
        check("abc_count0", count, 0);

        // Fill, then overflow
        for (int i = 0; i < 8; i++) push(8'(i));
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        check("fill_ovr0", overrun, 0);
        push(8'hAA);
        check("ovf_full", full, 1);
        check("ovf_count", count, 8);
        check("ovf_overrun", overrun, 1);
        for (int i = 0; i < 8; i++) pop_check("ovf_pop", 8'(i));
        check("ovf_drained", empty, 1);
        check("ovf_sticky", overrun, 1);
        clr_flags = 1'b1;
        tick();
        check("ovf_clr", overrun, 0);

        // Push+pop at full, across pointer wrap
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int i = 0; i < 20; i++) begin
            push_pop("full_pp_rd", 8'(8'h55 + i), (i < 8) ? 8'(i) : 8'(8'h55 + i - 8));
            check("full_pp_count", count, 8);
            check("full_pp_ovr", overrun, 0);
        end
        for (int i = 12; i < 20; i++) pop_check("wrap_drain", 8'(8'h55 + i));
        check("wrap_empty", empty, 1);

        // Break handling
        rx_valid = 1'b1;
        rx_break = 1'b1;
        rx_data  = 8'h00;
        tick();
        check("brk_set", brk, 1);
        check("brk_count", count, 0);
        check("brk_empty", empty, 1);
        clr_flags = 1'b1;
        rx_break  = 1'b1;
        tick();
        check("brk_clr_vs_set", brk, 1);
        clr_flags = 1'b1;
        tick();
        check("brk_clr", brk, 0);
        rx_break = 1'b1;
        tick();
        check("brk_novalid", brk, 1);
        clr_flags = 1'b1;
        tick();
        check("brk_clr2", brk, 0);

        // Threshold
        push(8'h10);
        push(8'h11);
        push(8'h12);
        check("lvl_3", level_hit, 0);
        push(8'h13);
        check("lvl_4", level_hit, 1);
        pop_check("lvl_pop", 8'h10);
        check("lvl_back3", level_hit, 0);
        check("lvl_count3", count, 3);
        push_pop("mid_pp_rd", 8'h14, 8'h11);
        check("mid_pp_count", count, 3);
        pop_check("lvl_d1", 8'h12);
        pop_check("lvl_d2", 8'h13);
        pop_check("lvl_d3", 8'h14);

        // Pop on empty
        rd_en = 1'b1;
        tick();
        check("epop_count", count, 0);
        check("epop_empty", empty, 1);
        check("epop_ovr", overrun, 0);
        check("epop_brk", brk, 0);

        // Push+pop on empty: only push happens
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        rd_en    = 1'b1;
        tick();
        check("epp_count", count, 1);
        pop_check("epp_rd", 8'h77);
        check("epp_empty", empty, 1);

        // Async reset mid-stream
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
        check("pre_rst_count", count, 5);
        rst_n = 1'b0;
        #1;
        check("arst_empty", empty, 1);
        check("arst_count", count, 0);
        check("arst_level", level_hit, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(8'h99);
        pop_check("post_rst_rd", 8'h99);
        check("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
